// File: rtl/decode_skid.sv
// RV32I decode stage with valid/ready handshakes on both sides.
// The instruction is decoded combinationally and captured into a main
// register; with SKID_EN=1 a second skid register lets ready_in come
// straight from a flop while still sustaining one transfer per cycle.
module decode_skid #(
  parameter int PC_W    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] pc_in,
  input  logic            valid_in,
  output logic            ready_in,
  input  logic            ready_out,
  output logic            valid_out,
  output logic [PC_W-1:0] pc_out,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [31:0]     imm,
  output logic [3:0]      alu_op,
  output logic [6:0]      opcode,
  output logic            uses_rs1,
  output logic            uses_rs2,
  output logic            writes_rd,
  output logic            illegal
);

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_ST    = 7'b0100011;
  localparam logic [6:0] OPC_OPI   = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [3:0]      aluOp;
    logic [6:0]      opcode;
    logic            usesRs1;
    logic            usesRs2;
    logic            writesRd;
    logic            illegal;
  } entry_t;

  entry_t      w_dec;
  entry_t      r_m;
  entry_t      r_s;
  logic        r_mValid;
  logic        r_sValid;
  logic        w_accept;
  logic [2:0]  w_f3;
  logic [31:0] w_immI;
  logic [31:0] w_immS;
  logic [31:0] w_immB;
  logic [31:0] w_immU;
  logic [31:0] w_immJ;

  assign w_f3   = instr[14:12];
  assign w_immI = {{20{instr[31]}}, instr[31:20]};
  assign w_immS = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign w_immB = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign w_immU = {instr[31:12], 12'b0};
  assign w_immJ = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Decode the incoming instruction; unused fields stay zero, unknown opcodes flag illegal.
  always_comb begin
    w_dec        = '0;
    w_dec.pc     = pc_in;
    w_dec.opcode = instr[6:0];
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC: begin
        w_dec.rd  = instr[11:7];
        w_dec.imm = w_immU;
      end
      OPC_JAL: begin
        w_dec.rd  = instr[11:7];
        w_dec.imm = w_immJ;
      end
      OPC_JALR, OPC_LD: begin
        w_dec.rs1     = instr[19:15];
        w_dec.rd      = instr[11:7];
        w_dec.usesRs1 = 1'b1;
        w_dec.imm     = w_immI;
      end
      OPC_OPI: begin
        w_dec.rs1     = instr[19:15];
        w_dec.rd      = instr[11:7];
        w_dec.usesRs1 = 1'b1;
        w_dec.imm     = w_immI;
        w_dec.aluOp   = {(w_f3 == 3'b101) & instr[30], w_f3};
      end
      OPC_OP: begin
        w_dec.rs1     = instr[19:15];
        w_dec.rs2     = instr[24:20];
        w_dec.rd      = instr[11:7];
        w_dec.usesRs1 = 1'b1;
        w_dec.usesRs2 = 1'b1;
        w_dec.aluOp   = {instr[30], w_f3};
      end
      OPC_BR: begin
        w_dec.rs1     = instr[19:15];
        w_dec.rs2     = instr[24:20];
        w_dec.usesRs1 = 1'b1;
        w_dec.usesRs2 = 1'b1;
        w_dec.imm     = w_immB;
        w_dec.aluOp   = {1'b0, w_f3};
      end
      OPC_ST: begin
        w_dec.rs1     = instr[19:15];
        w_dec.rs2     = instr[24:20];
        w_dec.usesRs1 = 1'b1;
        w_dec.usesRs2 = 1'b1;
        w_dec.imm     = w_immS;
      end
      default: w_dec.illegal = 1'b1;
    endcase
    w_dec.writesRd = !w_dec.illegal && (w_dec.rd != 5'd0);
  end

  assign ready_in = SKID_EN ? !r_sValid : (!r_mValid || ready_out);
  assign w_accept = valid_in && ready_in && !flush;

  // Main/skid register update: reset beats flush, flush beats any new accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_m      <= '0;
      r_s      <= '0;
      r_mValid <= 1'b0;
      r_sValid <= 1'b0;
    end else if (flush) begin
      r_mValid <= 1'b0;
      r_sValid <= 1'b0;
    end else if (SKID_EN) begin
      if (!r_mValid || ready_out) begin
        if (r_sValid) begin
          r_m      <= r_s;
          r_mValid <= 1'b1;
          r_sValid <= 1'b0;
        end else if (w_accept) begin
          r_m      <= w_dec;
          r_mValid <= 1'b1;
        end else begin
          r_mValid <= 1'b0;
        end
      end else if (w_accept) begin
        r_s      <= w_dec;
        r_sValid <= 1'b1;
      end
    end else begin
      if (w_accept) begin
        r_m      <= w_dec;
        r_mValid <= 1'b1;
      end else if (ready_out) begin
        r_mValid <= 1'b0;
      end
    end
  end

  assign valid_out = r_mValid;
  assign pc_out    = r_m.pc;
  assign rs1       = r_m.rs1;
  assign rs2       = r_m.rs2;
  assign rd        = r_m.rd;
  assign imm       = r_m.imm;
  assign alu_op    = r_m.aluOp;
  assign opcode    = r_m.opcode;
  assign uses_rs1  = r_m.usesRs1;
  assign uses_rs2  = r_m.usesRs2;
  assign writes_rd = r_m.writesRd;
  assign illegal   = r_m.illegal;

endmodule

// File: tb/tb_decode_skid.sv
// Bench for decode_skid: one instance with the skid buffer and one without,
// both fed the same stimulus and each checked against its own queue model.
module tb_decode_skid;

  logic        clk = 1'b0;
  logic        reset, flush, valid_in, ready_out;
  logic [31:0] instr, pc_in;

  logic        aRin, aVout, aU1, aU2, aWr, aIll;
  logic [31:0] aPc, aImm;
  logic [4:0]  aRs1, aRs2, aRd;
  logic [3:0]  aAlu;
  logic [6:0]  aOpc;
  logic        bRin, bVout, bU1, bU2, bWr, bIll;
  logic [31:0] bPc, bImm;
  logic [4:0]  bRs1, bRs2, bRd;
  logic [3:0]  bAlu;
  logic [6:0]  bOpc;
  logic [93:0] aObs, bObs;

  int errors = 0;
  int checks = 0;
  logic [93:0] qa[$];
  logic [93:0] qb[$];
  bit arA = 1'b1;
  bit arB = 1'b1;
  logic [6:0] opList [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  decode_skid #(.PC_W(32), .SKID_EN(1'b1)) dutA (
    .clk(clk), .reset(reset), .flush(flush), .instr(instr), .pc_in(pc_in),
    .valid_in(valid_in), .ready_in(aRin), .ready_out(ready_out), .valid_out(aVout),
    .pc_out(aPc), .rs1(aRs1), .rs2(aRs2), .rd(aRd), .imm(aImm), .alu_op(aAlu),
    .opcode(aOpc), .uses_rs1(aU1), .uses_rs2(aU2), .writes_rd(aWr), .illegal(aIll));

  decode_skid #(.PC_W(32), .SKID_EN(1'b0)) dutB (
    .clk(clk), .reset(reset), .flush(flush), .instr(instr), .pc_in(pc_in),
    .valid_in(valid_in), .ready_in(bRin), .ready_out(ready_out), .valid_out(bVout),
    .pc_out(bPc), .rs1(bRs1), .rs2(bRs2), .rd(bRd), .imm(bImm), .alu_op(bAlu),
    .opcode(bOpc), .uses_rs1(bU1), .uses_rs2(bU2), .writes_rd(bWr), .illegal(bIll));

  assign aObs = {aPc, aRs1, aRs2, aRd, aImm, aAlu, aOpc, aU1, aU2, aWr, aIll};
  assign bObs = {bPc, bRs1, bRs2, bRd, bImm, bAlu, bOpc, bU1, bU2, bWr, bIll};

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Expected decode straight from the ISA field rules, packed like aObs/bObs.
  function automatic logic [93:0] refDecode(logic [31:0] i, logic [31:0] pc);
    logic [6:0]  op;
    logic [31:0] im;
    logic [3:0]  alu;
    bit          hasRs1, hasRs2, hasRd, wr;
    op = i[6:0];
    if (!(op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33}))
      return {pc, 15'd0, 32'd0, 4'd0, op, 4'b0001};
    hasRs1 = !(op inside {7'h37, 7'h17, 7'h6F});
    hasRs2 = op inside {7'h33, 7'h63, 7'h23};
    hasRd  = !(op inside {7'h63, 7'h23});
    if (op inside {7'h37, 7'h17})  im = {i[31:12], 12'h000};
    else if (op == 7'h6F)          im = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    else if (op == 7'h63)          im = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    else if (op == 7'h23)          im = {{20{i[31]}}, i[31:25], i[11:7]};
    else if (op == 7'h33)          im = 32'd0;
    else                           im = {{20{i[31]}}, i[31:20]};
    if (op == 7'h33)      alu = {i[30], i[14:12]};
    else if (op == 7'h13) alu = {(i[14:12] == 3'd5) && i[30], i[14:12]};
    else if (op == 7'h63) alu = {1'b0, i[14:12]};
    else                  alu = 4'd0;
    wr = hasRd && (i[11:7] != 5'd0);
    return {pc, hasRs1 ? i[19:15] : 5'd0, hasRs2 ? i[24:20] : 5'd0, hasRd ? i[11:7] : 5'd0,
            im, alu, op, hasRs1, hasRs2, wr, 1'b0};
  endfunction

  // Single comparison point: counts the check and reports any difference.
  task automatic chk(string tag, logic [93:0] obs, logic [93:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare one instance's handshake and head-of-queue data with its model.
  task automatic checkOutput(string tag, logic vout, logic rin, logic [93:0] obs,
                             int cnt, logic [93:0] front, logic rdyExp, bit ar);
    chk({tag, ".valid_out"}, 94'(vout), 94'(cnt > 0));
    chk({tag, ".ready_in"}, 94'(rin), 94'(rdyExp));
    if (cnt > 0) chk({tag, ".data"}, obs, front);
    else if (ar) chk({tag, ".reset_data"}, obs, 94'd0);
  endtask

  // One clock: check before the edge, then advance both models on the edge.
  task automatic step();
    bit hsA, accA, hsB, accB, rs, fl;
    logic [93:0] cur;
    #1;
    checkOutput("skid", aVout, aRin, aObs, qa.size(), (qa.size() > 0) ? qa[0] : 94'd0,
                qa.size() < 2, arA);
    checkOutput("noskid", bVout, bRin, bObs, qb.size(), (qb.size() > 0) ? qb[0] : 94'd0,
                (qb.size() == 0) || ready_out, arB);
    hsA = aVout && ready_out;  accA = valid_in && aRin;
    hsB = bVout && ready_out;  accB = valid_in && bRin;
    cur = refDecode(instr, pc_in);
    rs  = reset;
    fl  = flush;
    @(posedge clk);
    if (!rs) begin
      qa.delete(); qb.delete(); arA = 1'b1; arB = 1'b1;
    end else begin
      if (hsA && qa.size() > 0) void'(qa.pop_front());
      if (hsB && qb.size() > 0) void'(qb.pop_front());
      if (fl) begin
        qa.delete(); qb.delete();
      end else begin
        if (accA) begin qa.push_back(cur); arA = 1'b0; end
        if (accB) begin qb.push_back(cur); arB = 1'b0; end
      end
    end
    @(negedge clk);
  endtask

  // Drive one cycle of inputs and run it.
  task automatic applyStimulus(logic vi, logic [31:0] ins, logic [31:0] pc, logic ro,
                               logic fl, logic rst);
    valid_in = vi; instr = ins; pc_in = pc; ready_out = ro; flush = fl; reset = rst;
    step();
  endtask

  function automatic logic [31:0] randInstr();
    int r;
    logic [31:0] x;
    r = $urandom_range(0, 9);
    x = $urandom;
    if (r < 9) x[6:0] = opList[r];
    return x;
  endfunction

  // Directed steps first, then a randomized stretch, then a drain.
  initial begin
    int idx;
    logic [31:0] pcCnt;
    reset = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_out = 1'b0; instr = '0; pc_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    applyStimulus(0, 32'h0, 32'h0, 1, 0, 1);

    applyStimulus(1, 32'hFFF10093, 32'h100, 1, 0, 1);
    chk("addi.imm", 94'(aImm), 94'(32'hFFFFFFFF));
    chk("addi.rs1", 94'(aRs1), 94'd2);
    chk("addi.rd", 94'(aRd), 94'd1);
    chk("addi.alu", 94'(aAlu), 94'd0);
    chk("addi.flags", 94'({aU2, aWr}), 94'(2'b01));
    applyStimulus(1, 32'h402081B3, 32'h104, 1, 0, 1);
    chk("sub.alu", 94'(aAlu), 94'(4'b1000));
    chk("sub.regs", 94'({aRs1, aRs2, aRd}), 94'({5'd1, 5'd2, 5'd3}));
    chk("sub.imm", 94'(aImm), 94'd0);
    applyStimulus(1, 32'hFE208EE3, 32'h108, 1, 0, 1);
    chk("beq.imm", 94'(aImm), 94'(32'hFFFFFFFC));
    chk("beq.rd", 94'({aRd, aWr}), 94'd0);
    applyStimulus(1, 32'h123452B7, 32'h10C, 1, 0, 1);
    chk("lui.imm", 94'(aImm), 94'(32'h12345000));
    chk("lui.rs1", 94'({aRs1, aU1, aRd}), 94'({5'd0, 1'b0, 5'd5}));
    applyStimulus(1, 32'h0000007F, 32'h110, 1, 0, 1);
    chk("ill.flags", 94'({aIll, aU1, aU2, aWr, aImm}), 94'({1'b1, 3'b000, 32'd0}));
    applyStimulus(0, 32'h0, 32'h0, 1, 0, 1);

    idx = 0;
    for (int c = 0; c < 12; c++) begin
      logic took;
      took = (idx < 4) && aRin;
      applyStimulus(idx < 4, 32'h00000013 | (idx << 7), 32'(idx * 4), !(c >= 2 && c <= 4), 0, 1);
      if (took) idx++;
    end

    applyStimulus(1, 32'h00100093, 32'h200, 0, 0, 1);
    applyStimulus(1, 32'h00200113, 32'h204, 0, 0, 1);
    applyStimulus(1, 32'h00300193, 32'h208, 0, 1, 1);
    chk("flush.valid_out", 94'(aVout), 94'd0);
    chk("flush.ready_in", 94'(aRin), 94'd1);
    repeat (3) applyStimulus(0, 32'h0, 32'h0, 1, 0, 1);

    applyStimulus(1, 32'h00400213, 32'h300, 0, 0, 1);
    applyStimulus(1, 32'h00500293, 32'h304, 0, 0, 1);
    applyStimulus(1, 32'h00600313, 32'h308, 0, 0, 0);
    chk("rst.valid_out", 94'({aVout, bVout}), 94'd0);
    chk("rst.data", aObs, 94'd0);
    applyStimulus(0, 32'h0, 32'h0, 1, 0, 1);

    pcCnt = 32'h1000;
    for (int c = 0; c < 600; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, randInstr(), pcCnt,
                    $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
                    $urandom_range(0, 149) != 0);
      pcCnt += 4;
    end

    repeat (4) applyStimulus(0, 32'h0, 32'h0, 1, 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
